// File: rtl/bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkg_bram_arb
// Purpose  : Shared types and helpers for the single-port BRAM arbiter.
//            Holds the FSM state encoding, the id-width helper and a packed
//            command record sized for the default configuration.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pkg_bram_arb;

    localparam int C_DATA_W  = 32;
    localparam int C_ADDR_W  = 8;
    localparam int C_NUM_REQ = 4;

    // Requester id width; a 2-requester arbiter still needs one id bit.
    function automatic int f_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int C_ID_W = f_id_w(C_NUM_REQ);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                we;
        logic [C_ADDR_W-1:0] addr;
        logic [C_DATA_W-1:0] wdata;
        logic [C_ID_W-1:0]   id;
    } bram_cmd_t;

endpackage
`default_nettype wire

// File: rtl/bram_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin priority picker. Finds the first set
//            request searching upward from ptr_i, wrapping modulo P_NUM_REQ.
// Ports    : req_i  - request vector
//            ptr_i  - highest-priority index this cycle
//            gnt_o  - one-hot grant (zero when no request)
//            idx_o  - binary index of the granted requester
//            any_o  - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import pkg_bram_arb::*;
#(
    parameter int P_NUM_REQ = 4,
    parameter int P_ID_W    = f_id_w(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] req_i,
    input  logic [P_ID_W-1:0]    ptr_i,
    output logic [P_NUM_REQ-1:0] gnt_o,
    output logic [P_ID_W-1:0]    idx_o,
    output logic                 any_o
);

    logic [2*P_NUM_REQ-1:0] w_dbl;
    logic [P_NUM_REQ-1:0]   w_rot;
    logic [P_ID_W-1:0]      w_off;
    logic                   w_found;
    logic [P_ID_W:0]        w_sum;

    // Rotating a doubled copy right by the pointer puts the highest-priority
    // requester at bit 0, so a plain lowest-bit-first scan does the RR search.
    assign w_dbl = {req_i, req_i};
    assign w_rot = P_NUM_REQ'(w_dbl >> ptr_i);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = P_ID_W'(i);
            end
        end
    end

    // Undo the rotation: index = (ptr + offset) mod P_NUM_REQ.
    always_comb begin
        w_sum = {1'b0, ptr_i} + {1'b0, w_off};
        if (w_sum >= (P_ID_W+1)'(P_NUM_REQ)) begin
            w_sum = w_sum - (P_ID_W+1)'(P_NUM_REQ);
        end
    end

    assign idx_o = P_ID_W'(w_sum);
    assign any_o = w_found;

    always_comb begin
        gnt_o = '0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            gnt_o[k] = w_found && (idx_o == P_ID_W'(k));
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_arbiter
// Purpose  : Round-robin arbiter sharing one single-port BRAM between
//            P_NUM_REQ valid/ready requesters. The winning command is staged
//            for one ACCESS cycle; every command gets a one-cycle rsp pulse.
// Ports    : clk, rst              - clock, async active-high reset
//            en                    - allow new grants
//            req_valid/ready/we    - per-requester handshake and direction
//            req_addr/req_wdata    - packed per-requester address / data
//            rsp_valid/rsp_rdata   - completion pulse and shared read data
//            busy                  - access in flight
//            bram_cs/we/oe/addr/data_i, bram_data_o - BRAM interface
// Revision : 1.0 - initial release
// ============================================================================
module bram_arbiter
    import pkg_bram_arb::*;
#(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 8,
    parameter int P_NUM_REQ    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [P_NUM_REQ-1:0]              req_valid,
    output logic [P_NUM_REQ-1:0]              req_ready,
    input  logic [P_NUM_REQ-1:0]              req_we,
    input  logic [P_NUM_REQ*P_ADDR_WIDTH-1:0] req_addr,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] req_wdata,
    output logic [P_NUM_REQ-1:0]              rsp_valid,
    output logic [P_DATA_WIDTH-1:0]           rsp_rdata,
    output logic                              busy,
    output logic                              bram_cs,
    output logic                              bram_we,
    output logic                              bram_oe,
    output logic [P_ADDR_WIDTH-1:0]           bram_addr,
    output logic [P_DATA_WIDTH-1:0]           bram_data_i,
    input  logic [P_DATA_WIDTH-1:0]           bram_data_o
);

    localparam int C_IDW = f_id_w(P_NUM_REQ);

    arb_state_t             state_q, state_d;
    logic [C_IDW-1:0]       ptr_q, ptr_d;
    logic                   we_q, we_d;
    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [P_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [C_IDW-1:0]       id_q, id_d;
    logic [P_NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [P_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [P_NUM_REQ-1:0]   w_gnt;
    logic [C_IDW-1:0]       w_idx;
    logic                   w_any;
    logic                   w_grant;

    rr_pick #(
        .P_NUM_REQ (P_NUM_REQ),
        .P_ID_W    (C_IDW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    // Granting is independent of state so a new command can be accepted in
    // the same cycle an access is in progress (one access per cycle).
    assign w_grant   = en && w_any;
    assign req_ready = w_grant ? w_gnt : '0;

    always_comb begin
        state_d     = IDLE;
        ptr_d       = ptr_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        id_d        = id_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;

        if (w_grant) begin
            state_d = ACCESS;
            ptr_d   = (w_idx == C_IDW'(P_NUM_REQ-1)) ? '0 : w_idx + 1'b1;
            id_d    = w_idx;
            for (int i = 0; i < P_NUM_REQ; i++) begin
                if (w_idx == C_IDW'(i)) begin
                    we_d    = req_we[i];
                    addr_d  = req_addr[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
                    wdata_d = req_wdata[i*P_DATA_WIDTH +: P_DATA_WIDTH];
                end
            end
        end

        // Completion of the access that is ending on this edge. Read data is
        // only sampled here, so a floating bus outside a read is never seen.
        if (state_q == ACCESS) begin
            for (int i = 0; i < P_NUM_REQ; i++) begin
                rsp_valid_d[i] = (id_q == C_IDW'(i));
            end
            rsp_rdata_d = we_q ? '0 : bram_data_o;
        end
    end

    always_comb begin
        bram_cs     = 1'b0;
        bram_we     = 1'b0;
        bram_oe     = 1'b0;
        bram_addr   = '0;
        bram_data_i = '0;
        if (state_q == ACCESS) begin
            bram_cs     = 1'b1;
            bram_we     = we_q;
            bram_oe     = !we_q;
            bram_addr   = addr_q;
            bram_data_i = we_q ? wdata_q : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            id_q        <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q == ACCESS);

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bram_arbiter
// Purpose  : Self-checking bench for bram_arbiter with a BRAM model, an
//            independent RR/grant model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            busy;
    logic            bram_cs, bram_we, bram_oe;
    logic [AW-1:0]   bram_addr;
    logic [DW-1:0]   bram_data_i;
    logic [DW-1:0]   bram_data_o;

    logic [AW-1:0]   a_addr  [N];
    logic [DW-1:0]   a_wdata [N];

    bram_arbiter #(
        .P_DATA_WIDTH (DW),
        .P_ADDR_WIDTH (AW),
        .P_NUM_REQ    (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .busy        (busy),
        .bram_cs     (bram_cs),
        .bram_we     (bram_we),
        .bram_oe     (bram_oe),
        .bram_addr   (bram_addr),
        .bram_data_i (bram_data_i),
        .bram_data_o (bram_data_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = a_addr[i];
            req_wdata[i*DW +: DW] = a_wdata[i];
        end
    end

    // BRAM model; a marker value stands in for the floating bus when oe is low.
    logic [DW-1:0] mem [256] = '{default: '0};
    always @(posedge clk) if (bram_cs && bram_we) mem[bram_addr] <= bram_data_i;
    assign bram_data_o = bram_oe ? mem[bram_addr] : 32'hBAD0_BAD0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct {
        int          id;
        logic        we;
        logic [DW-1:0] rdata;
        int          due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] shadow [256] = '{default: '0};
    int            m_ptr = 0;
    logic          m_acc_valid = 1'b0;
    logic          m_acc_we;
    logic [AW-1:0] m_acc_addr;
    logic [DW-1:0] m_acc_wdata;

    task automatic monitor_step();
        int       w;
        int       j;
        logic [N-1:0] er;
        exp_t     e;
        if (rst) begin
            m_ptr       = 0;
            m_acc_valid = 1'b0;
            exp_q.delete();
            check("rst_busy",  busy, 0);
            check("rst_cs",    bram_cs, 0);
            check("rst_rsp",   rsp_valid, 0);
            check("rst_rdata", rsp_rdata, 0);
        end else begin
            check("cs",   bram_cs, m_acc_valid);
            check("busy", busy, m_acc_valid);
            check("we",   bram_we, m_acc_valid & m_acc_we);
            check("oe",   bram_oe, m_acc_valid & ~m_acc_we);
            if (m_acc_valid) begin
                check("addr", bram_addr, m_acc_addr);
                if (m_acc_we) check("wdata", bram_data_i, m_acc_wdata);
            end else begin
                check("addr_idle", bram_addr, 0);
            end

            if (rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexp", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id",   rsp_valid, 64'd1 << e.id);
                    check("rsp_cyc",  cyc, e.due);
                    check("rsp_data", rsp_rdata, e.we ? '0 : e.rdata);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("rsp_miss", rsp_valid, 64'd1 << e.id);
            end

            w = -1;
            if (en) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (w < 0 && req_valid[j]) w = j;
                end
            end
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            check("ready", req_ready, er);

            if (w >= 0) begin
                e.id    = w;
                e.we    = req_we[w];
                e.rdata = req_we[w] ? '0 : shadow[a_addr[w]];
                e.due   = cyc + 2;
                exp_q.push_back(e);
                if (req_we[w]) shadow[a_addr[w]] = a_wdata[w];
                m_acc_valid = 1'b1;
                m_acc_we    = req_we[w];
                m_acc_addr  = a_addr[w];
                m_acc_wdata = a_wdata[w];
                m_ptr       = (w + 1) % N;
            end else begin
                m_acc_valid = 1'b0;
            end
        end
    endtask

    always @(negedge clk) monitor_step();

    // Stimulus helpers
    task automatic set_cmd(input int id, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_we[id]    = we;
        a_addr[id]    = addr;
        a_wdata[id]   = data;
        req_valid[id] = 1'b1;
    endtask

    task automatic issue(input int id);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        check("issue_timeout", ok, 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic take(input int id, input string tag, input logic [N-1:0] exp_rdy);
        @(negedge clk);
        check(tag, req_ready, exp_rdy);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_we    = '0;
        for (int i = 0; i < N; i++) begin
            a_addr[i]  = '0;
            a_wdata[i] = '0;
        end
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        @(posedge clk); #1;
        en = 1'b1;

        // Single write then read through requester 0
        set_cmd(0, 1'b1, 8'h10, 32'hDEAD_BEEF);
        issue(0);
        @(negedge clk);
        check("t1_we",   bram_we, 1);
        check("t1_addr", bram_addr, 8'h10);
        @(posedge clk); #1;
        set_cmd(0, 1'b0, 8'h10, '0);
        issue(0);
        idle(3);
        @(negedge clk);
        check("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);

        // Preload addresses 1..4 so the RR reads return distinct data
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            set_cmd(0, 1'b1, AW'(i), 32'h1000 + i);
            issue(0);
        end
        idle(3);

        // All four requesters reading continuously from reset
        do_reset();
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, AW'(i + 1), '0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_order", req_ready, 4'b0001 << (k % 4));
        end
        @(posedge clk); #1;
        req_valid = '0;
        idle(3);

        // Pointer at 3 with only req1 valid, then show pointer moved to 2
        set_cmd(2, 1'b0, 8'h20, '0);
        take(2, "wrap_pre", 4'b0100);
        set_cmd(1, 1'b0, 8'h10, '0);
        take(1, "wrap_gnt", 4'b0010);
        set_cmd(1, 1'b0, 8'h01, '0);
        set_cmd(2, 1'b0, 8'h02, '0);
        take(2, "wrap_ptr", 4'b0100);
        take(1, "wrap_next", 4'b0010);
        idle(3);

        // Back-to-back write then read of the same address
        set_cmd(2, 1'b1, 8'h55, 32'hA5A5_A5A5);
        set_cmd(3, 1'b0, 8'h55, '0);
        take(2, "raw_w", 4'b0100);
        take(3, "raw_r", 4'b1000);
        idle(3);
        @(negedge clk);
        check("raw_data", rsp_rdata, 32'hA5A5_A5A5);

        // en low holds off grants
        @(posedge clk); #1;
        en = 1'b0;
        set_cmd(0, 1'b0, 8'h03, '0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("en_ready", req_ready, 0);
            check("en_cs",    bram_cs, 0);
        end
        @(posedge clk); #1;
        en = 1'b1;
        take(0, "en_gnt", 4'b0001);
        idle(3);

        // Reset during a read ACCESS
        set_cmd(1, 1'b0, 8'h10, '0);
        take(1, "pre_rst", 4'b0010);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",  busy, 0);
        check("arst_cs",    bram_cs, 0);
        check("arst_oe",    bram_oe, 0);
        check("arst_addr",  bram_addr, 0);
        check("arst_rsp",   rsp_valid, 0);
        check("arst_rdata", rsp_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_cmd(1, 1'b0, 8'h04, '0);
        set_cmd(2, 1'b0, 8'h02, '0);
        take(1, "post_rst", 4'b0010);
        take(2, "post_rst2", 4'b0100);
        idle(5);

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
